// File: rtl/axi_core_slice_if.sv
// axi_core_slice_if: AXI4 five-channel bundle shared by the core-side and bus-side ports of the slice.
interface axi_core_slice_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ADDR_W-1:0]   araddr, awaddr;
    logic [ID_W-1:0]     arid, awid, rid, bid;
    logic [7:0]          arlen, awlen;
    logic [2:0]          arsize, awsize, arprot, awprot;
    logic [1:0]          arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]          arcache, awcache;
    logic [DATA_W-1:0]   wdata, rdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                arvalid, arready, awvalid, awready;
    logic                wlast, wvalid, wready, rlast, rvalid, rready, bvalid, bready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        output awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        input  awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_core_slice.sv
// axi_core_slice: per-channel skid/bypass AXI4 register slice with outstanding-burst limiter and underflow flag.
module axi_core_slice_buf #(
    parameter int W    = 1,
    parameter bit SKID = 1'b1
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         run,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    if (SKID) begin : g_skid
        logic [W-1:0] mem [2];
        logic [1:0]   cnt;
        logic         rd, push, pop;
        assign in_ready  = run & ~cnt[1];
        assign out_valid = cnt != 2'd0;
        assign out_data  = mem[rd];
        assign push      = in_valid & in_ready;
        assign pop       = out_valid & out_ready;
        // write slot is the one after the head when a single entry is held
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                mem[0] <= '0;
                mem[1] <= '0;
                cnt    <= 2'd0;
                rd     <= 1'b0;
            end else begin
                if (push) mem[rd ^ cnt[0]] <= in_data;
                if (pop) rd <= ~rd;
                cnt <= cnt + {1'b0, push} - {1'b0, pop};
            end
        end
    end else begin : g_byp
        assign out_valid = in_valid & run;
        assign in_ready  = out_ready & run;
        assign out_data  = in_data;
    end
endmodule

module axi_core_slice #(
    parameter int       ADDR_W   = 32,
    parameter int       DATA_W   = 32,
    parameter int       ID_W     = 4,
    parameter int       MAX_OUTS = 4,
    parameter bit [4:0] CH_MODE  = 5'b11111
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    axi_core_slice_if.slave               s,
    axi_core_slice_if.master              m,
    output logic [$clog2(MAX_OUTS+1)-1:0] rd_outs,
    output logic [$clog2(MAX_OUTS+1)-1:0] wr_outs,
    output logic                          resp_err
);
    localparam int CW  = $clog2(MAX_OUTS+1);
    localparam int A_W = ADDR_W + ID_W + 22;
    localparam int W_W = DATA_W + DATA_W/8 + 1;
    localparam int R_W = ID_W + DATA_W + 3;
    localparam int B_W = ID_W + 2;

    logic           run, rd_ok, wr_ok, ar_rdy, aw_rdy;
    logic           rd_inc, rd_dec, wr_inc, wr_dec;
    logic [CW-1:0]  rd_nxt, wr_nxt;
    logic [A_W-1:0] ar_out, aw_out;
    logic [W_W-1:0] w_out;
    logic [R_W-1:0] r_out;
    logic [B_W-1:0] b_out;

    // limit gates only the core side so a beat already offered to the bus is never withdrawn
    assign rd_ok     = rd_outs != CW'(MAX_OUTS);
    assign wr_ok     = wr_outs != CW'(MAX_OUTS);
    assign s.arready = ar_rdy & rd_ok;
    assign s.awready = aw_rdy & wr_ok;

    axi_core_slice_buf #(.W(A_W), .SKID(CH_MODE[0])) u_ar (
        .aclk, .aresetn, .run,
        .in_valid(s.arvalid & rd_ok), .in_ready(ar_rdy),
        .in_data({s.araddr, s.arid, s.arlen, s.arsize, s.arburst, s.arlock, s.arcache, s.arprot}),
        .out_valid(m.arvalid), .out_ready(m.arready), .out_data(ar_out)
    );
    assign {m.araddr, m.arid, m.arlen, m.arsize, m.arburst, m.arlock, m.arcache, m.arprot} = ar_out;

    axi_core_slice_buf #(.W(A_W), .SKID(CH_MODE[1])) u_aw (
        .aclk, .aresetn, .run,
        .in_valid(s.awvalid & wr_ok), .in_ready(aw_rdy),
        .in_data({s.awaddr, s.awid, s.awlen, s.awsize, s.awburst, s.awlock, s.awcache, s.awprot}),
        .out_valid(m.awvalid), .out_ready(m.awready), .out_data(aw_out)
    );
    assign {m.awaddr, m.awid, m.awlen, m.awsize, m.awburst, m.awlock, m.awcache, m.awprot} = aw_out;

    axi_core_slice_buf #(.W(W_W), .SKID(CH_MODE[2])) u_w (
        .aclk, .aresetn, .run,
        .in_valid(s.wvalid), .in_ready(s.wready), .in_data({s.wdata, s.wstrb, s.wlast}),
        .out_valid(m.wvalid), .out_ready(m.wready), .out_data(w_out)
    );
    assign {m.wdata, m.wstrb, m.wlast} = w_out;

    axi_core_slice_buf #(.W(R_W), .SKID(CH_MODE[3])) u_r (
        .aclk, .aresetn, .run,
        .in_valid(m.rvalid), .in_ready(m.rready), .in_data({m.rid, m.rdata, m.rresp, m.rlast}),
        .out_valid(s.rvalid), .out_ready(s.rready), .out_data(r_out)
    );
    assign {s.rid, s.rdata, s.rresp, s.rlast} = r_out;

    axi_core_slice_buf #(.W(B_W), .SKID(CH_MODE[4])) u_b (
        .aclk, .aresetn, .run,
        .in_valid(m.bvalid), .in_ready(m.bready), .in_data({m.bid, m.bresp}),
        .out_valid(s.bvalid), .out_ready(s.bready), .out_data(b_out)
    );
    assign {s.bid, s.bresp} = b_out;

    assign rd_inc = s.arvalid & s.arready;
    assign rd_dec = m.rvalid & m.rready & m.rlast;
    assign wr_inc = s.awvalid & s.awready;
    assign wr_dec = m.bvalid & m.bready;

    always_comb begin
        rd_nxt = (rd_inc & ~rd_dec) ? rd_outs + CW'(1) :
                 (rd_dec & ~rd_inc & rd_outs != '0) ? rd_outs - CW'(1) : rd_outs;
        wr_nxt = (wr_inc & ~wr_dec) ? wr_outs + CW'(1) :
                 (wr_dec & ~wr_inc & wr_outs != '0) ? wr_outs - CW'(1) : wr_outs;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run      <= 1'b0;
            rd_outs  <= '0;
            wr_outs  <= '0;
            resp_err <= 1'b0;
        end else begin
            run     <= 1'b1;
            rd_outs <= rd_nxt;
            wr_outs <= wr_nxt;
            if ((rd_dec && rd_outs == '0) || (wr_dec && wr_outs == '0)) resp_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_core_slice.sv
// tb_axi_core_slice: queue-based reference model for a skid-mode slice plus a vector table for a bypass-mode slice.
module tb_axi_core_slice;
    logic aclk = 1'b0, aresetn = 1'b1;
    always #10 aclk = ~aclk;

    axi_core_slice_if sa (), sm (), ba (), bm ();
    logic [1:0] rd_s, wr_s, rd_b, wr_b;
    logic       err_s, err_b;

    axi_core_slice #(.MAX_OUTS(2), .CH_MODE(5'b11111)) dut_s (
        .aclk(aclk), .aresetn(aresetn), .s(sa), .m(sm), .rd_outs(rd_s), .wr_outs(wr_s), .resp_err(err_s)
    );
    axi_core_slice #(.MAX_OUTS(2), .CH_MODE(5'b00000)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .s(ba), .m(bm), .rd_outs(rd_b), .wr_outs(wr_b), .resp_err(err_b)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    // reference model: each skid channel is a 2-deep queue, counters follow the handshake rules
    logic [43:0] arq[$], awq[$];
    logic [36:0] wq[$], rq[$];
    logic [5:0]  bq[$];
    int rd_c, wr_c;
    bit m_err, m_run;
    bit h_ar_in, h_ar_out, h_aw_in, h_aw_out, h_w_in, h_w_out, h_r_in, h_r_out, h_b_in, h_b_out;

    task automatic clear_model();
        arq.delete(); awq.delete(); wq.delete(); rq.delete(); bq.delete();
        rd_c = 0; wr_c = 0; m_err = 0; m_run = 0;
    endtask

    task automatic idle();
        sa.araddr = 0; sa.arid = 0; sa.arlen = 0; sa.arsize = 0; sa.arburst = 0; sa.arlock = 0; sa.arcache = 0; sa.arprot = 0; sa.arvalid = 0;
        sa.awaddr = 0; sa.awid = 0; sa.awlen = 0; sa.awsize = 0; sa.awburst = 0; sa.awlock = 0; sa.awcache = 0; sa.awprot = 0; sa.awvalid = 0;
        sa.wdata = 0; sa.wstrb = 0; sa.wlast = 0; sa.wvalid = 0; sa.rready = 0; sa.bready = 0;
        sm.arready = 0; sm.awready = 0; sm.wready = 0; sm.rid = 0; sm.rdata = 0; sm.rresp = 0; sm.rlast = 0; sm.rvalid = 0;
        sm.bid = 0; sm.bresp = 0; sm.bvalid = 0;
        ba.araddr = 0; ba.arid = 0; ba.arlen = 0; ba.arsize = 0; ba.arburst = 0; ba.arlock = 0; ba.arcache = 0; ba.arprot = 0; ba.arvalid = 0;
        ba.awaddr = 0; ba.awid = 0; ba.awlen = 0; ba.awsize = 0; ba.awburst = 0; ba.awlock = 0; ba.awcache = 0; ba.awprot = 0; ba.awvalid = 0;
        ba.wdata = 0; ba.wstrb = 0; ba.wlast = 0; ba.wvalid = 0; ba.rready = 0; ba.bready = 0;
        bm.arready = 0; bm.awready = 0; bm.wready = 0; bm.rid = 0; bm.rdata = 0; bm.rresp = 0; bm.rlast = 0; bm.rvalid = 0;
        bm.bid = 0; bm.bresp = 0; bm.bvalid = 0;
    endtask

    task automatic check_skid();
        bit e;
        e = m_run && arq.size() < 2 && rd_c < 2;
        chk("s_arready", sa.arready, e); h_ar_in = sa.arvalid && e;
        chk("m_arvalid", sm.arvalid, arq.size() != 0); h_ar_out = arq.size() != 0 && sm.arready;
        if (arq.size() != 0) chk("m_ar_payload", {sm.arid, sm.arlen, sm.araddr}, arq[0]);
        e = m_run && awq.size() < 2 && wr_c < 2;
        chk("s_awready", sa.awready, e); h_aw_in = sa.awvalid && e;
        chk("m_awvalid", sm.awvalid, awq.size() != 0); h_aw_out = awq.size() != 0 && sm.awready;
        if (awq.size() != 0) chk("m_aw_payload", {sm.awid, sm.awlen, sm.awaddr}, awq[0]);
        e = m_run && wq.size() < 2;
        chk("s_wready", sa.wready, e); h_w_in = sa.wvalid && e;
        chk("m_wvalid", sm.wvalid, wq.size() != 0); h_w_out = wq.size() != 0 && sm.wready;
        if (wq.size() != 0) chk("m_w_payload", {sm.wlast, sm.wstrb, sm.wdata}, wq[0]);
        e = m_run && rq.size() < 2;
        chk("m_rready", sm.rready, e); h_r_in = sm.rvalid && e;
        chk("s_rvalid", sa.rvalid, rq.size() != 0); h_r_out = rq.size() != 0 && sa.rready;
        if (rq.size() != 0) chk("s_r_payload", {sa.rlast, sa.rid, sa.rdata}, rq[0]);
        e = m_run && bq.size() < 2;
        chk("m_bready", sm.bready, e); h_b_in = sm.bvalid && e;
        chk("s_bvalid", sa.bvalid, bq.size() != 0); h_b_out = bq.size() != 0 && sa.bready;
        if (bq.size() != 0) chk("s_b_payload", {sa.bid, sa.bresp}, bq[0]);
        chk("rd_outs", rd_s, rd_c);
        chk("wr_outs", wr_s, wr_c);
        chk("resp_err", err_s, m_err);
    endtask

    task automatic update();
        bit rdec;
        if (!aresetn) return;
        if (h_ar_out) void'(arq.pop_front());
        if (h_ar_in) arq.push_back({sa.arid, sa.arlen, sa.araddr});
        if (h_aw_out) void'(awq.pop_front());
        if (h_aw_in) awq.push_back({sa.awid, sa.awlen, sa.awaddr});
        if (h_w_out) void'(wq.pop_front());
        if (h_w_in) wq.push_back({sa.wlast, sa.wstrb, sa.wdata});
        if (h_r_out) void'(rq.pop_front());
        if (h_r_in) rq.push_back({sm.rlast, sm.rid, sm.rdata});
        if (h_b_out) void'(bq.pop_front());
        if (h_b_in) bq.push_back({sm.bid, sm.bresp});
        rdec = h_r_in && sm.rlast;
        if ((rdec && rd_c == 0) || (h_b_in && wr_c == 0)) m_err = 1;
        rd_c += (h_ar_in && !rdec) ? 1 : (!h_ar_in && rdec && rd_c > 0) ? -1 : 0;
        wr_c += (h_aw_in && !h_b_in) ? 1 : (!h_aw_in && h_b_in && wr_c > 0) ? -1 : 0;
        m_run = 1;
    endtask

    task automatic tick();
        #4;
        check_skid();
        @(posedge aclk);
        update();
        @(negedge aclk);
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] addr;
        logic        mrdy;
        logic        e_mvld;
        logic        e_srdy;
        logic [1:0]  e_rd;
    } vec_t;
    vec_t vt[6];

    initial begin
        int sent, got, cyc;
        bit pat[4];
        vt[0] = '{1'b1, 32'h1C00_0000, 1'b0, 1'b1, 1'b0, 2'd0};
        vt[1] = '{1'b1, 32'h1C00_0000, 1'b1, 1'b1, 1'b1, 2'd0};
        vt[2] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 2'd1};
        vt[3] = '{1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 2'd1};
        vt[4] = '{1'b1, 32'hAAAA_5555, 1'b1, 1'b0, 1'b0, 2'd2};
        vt[5] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 2'd2};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        idle();
        clear_model();
        #1 aresetn = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        aresetn = 1'b1;
        tick();
        chk("s_arready_after_release", sa.arready, 1);
        tick();

        foreach (vt[i]) begin
            ba.arvalid = vt[i].vld; ba.araddr = vt[i].addr; bm.arready = vt[i].mrdy;
            #2;
            chk("byp_m_arvalid", bm.arvalid, vt[i].e_mvld);
            chk("byp_s_arready", ba.arready, vt[i].e_srdy);
            chk("byp_m_araddr", bm.araddr, vt[i].addr);
            chk("byp_rd_outs", rd_b, vt[i].e_rd);
            tick();
        end
        ba.arvalid = 0; bm.arready = 0;

        sent = 0; got = 0; cyc = 0;
        while ((sent < 8 || wq.size() != 0) && cyc < 200) begin
            sa.wvalid = sent < 8; sa.wdata = 32'hA0 + sent; sa.wstrb = 4'hF; sa.wlast = sent == 7;
            sm.wready = pat[cyc % 4];
            tick();
            sent += int'(h_w_in); got += int'(h_w_out); cyc++;
        end
        sa.wvalid = 0; sm.wready = 0;
        chk("w_beats_delivered", got, 8);

        sa.arvalid = 1; sa.araddr = 32'h1000; sm.arready = 1;
        tick(); sa.araddr = 32'h1004;
        tick(); sa.araddr = 32'h1008;
        chk("rd_outs_full", rd_s, 2);
        chk("s_arready_at_limit", sa.arready, 0);
        tick(); tick();
        chk("rd_outs_held", rd_s, 2);
        sm.rvalid = 1; sm.rlast = 1; sm.rid = 4'h1; sm.rdata = 32'hD0; sa.rready = 1;
        tick(); sm.rvalid = 0;
        chk("rd_outs_after_rlast", rd_s, 1);
        chk("s_arready_after_rlast", sa.arready, 1);
        tick(); sa.arvalid = 0;
        chk("rd_outs_third_ar", rd_s, 2);
        sm.rvalid = 1; tick(); tick(); sm.rvalid = 0; sm.rlast = 0;
        chk("rd_outs_drained", rd_s, 0);
        tick(); tick(); sm.arready = 0;

        sa.awvalid = 1; sa.awaddr = 32'h2000; sm.awready = 1;
        tick(); sa.awvalid = 0;
        chk("wr_outs_one", wr_s, 1);
        sa.awvalid = 1; sa.awaddr = 32'h2004; sm.bvalid = 1; sa.bready = 1;
        tick(); sa.awvalid = 0;
        chk("wr_outs_simultaneous", wr_s, 1);
        tick(); sm.bvalid = 0;
        chk("wr_outs_zero", wr_s, 0);
        chk("resp_err_clear", err_s, 0);
        tick(); tick();
        sm.bvalid = 1; tick(); sm.bvalid = 0;
        chk("resp_err_underflow", err_s, 1);
        chk("wr_outs_underflow", wr_s, 0);
        tick(); tick(); tick(); sm.awready = 0;

        sa.rready = 0; sm.rvalid = 1; sm.rlast = 0; sm.rdata = 32'hBEEF;
        tick(); sm.rdata = 32'hCAFE; tick(); sm.rvalid = 0;
        chk("r_beats_buffered", sa.rvalid, 1);
        aresetn = 1'b0; clear_model();
        #1;
        chk("s_rvalid_reset", sa.rvalid, 0);
        chk("resp_err_reset", err_s, 0);
        chk("m_rready_reset", sm.rready, 0);
        tick(); tick();
        aresetn = 1'b1;
        tick(); tick();

        for (int i = 0; i < 400; i++) begin
            sa.arvalid = 1'($urandom); sa.araddr = $urandom; sa.arid = 4'($urandom); sa.arlen = 8'($urandom);
            sm.arready = $urandom_range(0, 9) < 7;
            sa.awvalid = 1'($urandom); sa.awaddr = $urandom; sa.awid = 4'($urandom); sa.awlen = 8'($urandom);
            sm.awready = $urandom_range(0, 9) < 7;
            sa.wvalid = 1'($urandom); sa.wdata = $urandom; sa.wstrb = 4'($urandom); sa.wlast = 1'($urandom);
            sm.wready = $urandom_range(0, 9) < 7;
            sm.rvalid = $urandom_range(0, 9) < 4; sm.rlast = 1'($urandom); sm.rid = 4'($urandom); sm.rdata = $urandom;
            sa.rready = $urandom_range(0, 9) < 7;
            sm.bvalid = $urandom_range(0, 9) < 3; sm.bid = 4'($urandom); sm.bresp = 2'($urandom);
            sa.bready = $urandom_range(0, 9) < 7;
            tick();
        end
        idle();
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
